// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding, default line
// rate and clock, and the clocks-per-bit computation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned BAUD_DEF = 115_200;
  localparam int unsigned CLK_DEF  = 50_000_000;

  function automatic int unsigned bit_cnt(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  localparam int unsigned BIT_CNT_DEF = bit_cnt(CLK_DEF, BAUD_DEF);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a one-cycle
// delayed copy used to detect falling edges.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q, sync_q, dly_q;

  // Flops come out of reset at the idle level so release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Define UART_RX_MAJORITY_EN to take every sample as the
// 2-of-3 majority of the synchronised line over the last three cycles.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD = BAUD_DEF,
  parameter int unsigned CLK  = CLK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BIT_CNT = bit_cnt(CLK, BAUD);
  localparam int unsigned CW      = $clog2(BIT_CNT);
  localparam logic [CW-1:0] HALF_C = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0] LAST_C = CW'(BIT_CNT - 1);

  logic rx_s, fall, samp;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], rx_s};
  end

  assign samp = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign samp = rx_s;
`endif

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          flag_q, flag_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    flag_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_C) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = samp ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          sh_d  = {samp, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a start bit right after it is still caught.
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (samp) begin
            data_d = sh_q;
            flag_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign po_data   = data_q;
  assign po_flag   = flag_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a model transmitter drives the line and
// received strobes are compared against expectations built from frame contents.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] po_data;
  logic       po_flag, frame_err, rx_busy;

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  localparam int BIT = 50_000_000 / 115_200;
  localparam int LAT = 3 + BIT / 2 + 9 * BIT;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        ev_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         both_cnt = 0;
  int         wide_cnt = 0;
  logic       pf = 1'b0, pe = 1'b0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (po_flag && frame_err) both_cnt++;
    if ((po_flag && pf) || (frame_err && pe)) wide_cnt++;
    if (po_flag)   ev_q.push_back('{1'b0, po_data, cyc});
    if (frame_err) ev_q.push_back('{1'b1, po_data, cyc});
    pf = po_flag;
    pe = frame_err;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    rx = v;
    for (int j = 1; j <= BIT; j++) begin
      @(posedge clk);
      #1;
      if (glitch && j == BIT / 2) rx = ~v;
      else                        rx = v;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch, output int t0);
    t0 = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
    drive_bit(stop, 1'b0);
    rx = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (po_data !== 8'h00) begin errors++; $display("FAIL %s po_data: got %h expected 00", tag, po_data); end
    checks++;
    if (po_flag !== 1'b0) begin errors++; $display("FAIL %s po_flag: got %b expected 0", tag, po_flag); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL %s frame_err: got %b expected 0", tag, frame_err); end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL %s rx_busy: got %b expected 0", tag, rx_busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    step(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    step(5);
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_release rx_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_basic();
    int t0;
    ev_q.delete();
    send_frame(8'h55, 1'b1, 1'b0, t0);
    step(100);
    checks++;
    if (ev_q.size() !== 1) begin errors++; $display("FAIL basic events: got %0d expected 1", ev_q.size()); end
    if (ev_q.size() > 0) begin
      checks++;
      if (ev_q[0].err !== 1'b0) begin errors++; $display("FAIL basic kind: got frame_err expected po_flag"); end
      checks++;
      if (ev_q[0].data !== 8'h55) begin errors++; $display("FAIL basic data: got %h expected 55", ev_q[0].data); end
      checks++;
      if ((ev_q[0].cyc - t0) < LAT - 1 || (ev_q[0].cyc - t0) > LAT + 1) begin
        errors++;
        $display("FAIL basic latency: got %0d expected %0d", ev_q[0].cyc - t0, LAT);
      end
    end
    last_good = 8'h55;
  endtask

  task automatic test_random();
    int         t0, gap;
    logic [7:0] b;
    logic       stop;
    bit         exp_err[$];
    logic [7:0] exp_dat[$];
    ev_q.delete();
    for (int f = 0; f < 4; f++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      exp_err.push_back(!stop);
      exp_dat.push_back(b);
      if (stop) last_good = b;
      send_frame(b, stop, 1'b0, t0);
      gap = stop ? $urandom_range(0, 40) : $urandom_range(10, 40);
      step(gap);
    end
    step(100);
    checks++;
    if (ev_q.size() !== exp_err.size()) begin
      errors++;
      $display("FAIL random events: got %0d expected %0d", ev_q.size(), exp_err.size());
    end else begin
      for (int i = 0; i < exp_err.size(); i++) begin
        checks++;
        if (ev_q[i].err !== exp_err[i]) begin
          errors++;
          $display("FAIL random kind[%0d]: got err=%b expected err=%b", i, ev_q[i].err, exp_err[i]);
        end else if (!exp_err[i]) begin
          checks++;
          if (ev_q[i].data !== exp_dat[i]) begin
            errors++;
            $display("FAIL random data[%0d]: got %h expected %h", i, ev_q[i].data, exp_dat[i]);
          end
        end
      end
    end
    checks++;
    if (po_data !== last_good) begin errors++; $display("FAIL random po_data: got %h expected %h", po_data, last_good); end
  endtask

  task automatic test_false_start();
    ev_q.delete();
    rx = 1'b0;
    step(50);
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_start busy: got %b expected 1", rx_busy); end
    step(50);
    rx = 1'b1;
    step(130);
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_start idle: got %b expected 0", rx_busy); end
    step(50);
    checks++;
    if (ev_q.size() !== 0) begin errors++; $display("FAIL false_start events: got %0d expected 0", ev_q.size()); end
  endtask

  task automatic test_frame_err();
    int t0;
    ev_q.delete();
    send_frame(8'h0F, 1'b0, 1'b0, t0);
    step(100);
    checks++;
    if (ev_q.size() !== 1) begin errors++; $display("FAIL frame_err events: got %0d expected 1", ev_q.size()); end
    if (ev_q.size() > 0) begin
      checks++;
      if (ev_q[0].err !== 1'b1) begin errors++; $display("FAIL frame_err kind: got po_flag expected frame_err"); end
    end
    checks++;
    if (po_data !== last_good) begin errors++; $display("FAIL frame_err po_data: got %h expected %h", po_data, last_good); end
  endtask

  task automatic test_back_to_back();
    int t0;
    ev_q.delete();
    send_frame(8'h0F, 1'b1, 1'b0, t0);
    send_frame(8'h02, 1'b1, 1'b0, t0);
    step(100);
    checks++;
    if (ev_q.size() !== 2) begin errors++; $display("FAIL b2b events: got %0d expected 2", ev_q.size()); end
    if (ev_q.size() == 2) begin
      checks++;
      if (ev_q[0].err || ev_q[0].data !== 8'h0F) begin errors++; $display("FAIL b2b first: got err=%b %h expected 0F", ev_q[0].err, ev_q[0].data); end
      checks++;
      if (ev_q[1].err || ev_q[1].data !== 8'h02) begin errors++; $display("FAIL b2b second: got err=%b %h expected 02", ev_q[1].err, ev_q[1].data); end
    end
    last_good = 8'h02;
  endtask

  task automatic test_reset_midframe();
    int         t0;
    logic [7:0] a = 8'hA5;
    ev_q.delete();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(a[i], 1'b0);
    rx = a[4];
    step(200);
    rst = 1'b1;
    step(1);
    check_idle_outputs("midframe_rst");
    step(4);
    rst = 1'b0;
    rx  = 1'b1;
    last_good = 8'h00;
    step(2 * BIT);
    checks++;
    if (ev_q.size() !== 0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe abort: got events=%0d busy=%b expected 0 0", ev_q.size(), rx_busy);
    end
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    step(100);
    checks++;
    if (ev_q.size() !== 1) begin errors++; $display("FAIL midframe events: got %0d expected 1", ev_q.size()); end
    if (ev_q.size() > 0) begin
      checks++;
      if (ev_q[0].err || ev_q[0].data !== 8'h3C) begin errors++; $display("FAIL midframe data: got err=%b %h expected 3C", ev_q[0].err, ev_q[0].data); end
    end
    last_good = 8'h3C;
  endtask

  task automatic test_glitch();
    int         t0;
    logic [7:0] b = 8'hC3;
    logic [7:0] exp;
    exp = MAJ ? b : ~b;
    ev_q.delete();
    send_frame(b, 1'b1, 1'b1, t0);
    step(100);
    checks++;
    if (ev_q.size() !== 1) begin errors++; $display("FAIL glitch events: got %0d expected 1", ev_q.size()); end
    checks++;
    if (po_data !== exp) begin errors++; $display("FAIL glitch data: got %h expected %h", po_data, exp); end
    last_good = exp;
  endtask

  task automatic test_low_from_reset();
    int t0;
    rst = 1'b1;
    rx  = 1'b0;
    step(3);
    rst = 1'b0;
    t0  = cyc;
    last_good = 8'h00;
    ev_q.delete();
    step(LAT + 20);
    checks++;
    if (ev_q.size() !== 1) begin errors++; $display("FAIL low_reset events: got %0d expected 1", ev_q.size()); end
    if (ev_q.size() > 0) begin
      checks++;
      if (ev_q[0].err !== 1'b1) begin errors++; $display("FAIL low_reset kind: got po_flag expected frame_err"); end
      checks++;
      if ((ev_q[0].cyc - t0) < LAT - 1 || (ev_q[0].cyc - t0) > LAT + 1) begin
        errors++;
        $display("FAIL low_reset latency: got %0d expected %0d", ev_q[0].cyc - t0, LAT);
      end
    end
    step(500);
    checks++;
    if (rx_busy !== 1'b0 || ev_q.size() !== 1) begin
      errors++;
      $display("FAIL low_reset restart: got busy=%b events=%0d expected 0 1", rx_busy, ev_q.size());
    end
    rx = 1'b1;
    step(50);
    checks++;
    if (po_data !== last_good) begin errors++; $display("FAIL low_reset po_data: got %h expected %h", po_data, last_good); end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
    checks++;
    if (wide_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d expected 0", wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_glitch();
    test_low_from_reset();
    test_strobe_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
